alu_share_arb: RTL and testbench

//  Shares a single ALU between two requesters (e.g. two issue slots/threads) with round-robin grant.

---
 rtl/alu_share_arb.sv | 163 ++++++++++++++++
 tb/tb_alu_share_arb.sv | 346 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_share_arb.sv
// alu_share_arb: one ALU shared by two requesters with round-robin grant.
// Screens opcodes, sequences the ALU through start/done under a timeout,
// and returns result + error to whichever requester owns the current op.
module alu_share_arb #(
    parameter int W       = 16,
    parameter int TIMEOUT = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [1:0]     req_valid,
    output logic [1:0]     req_ready,
    input  logic [9:0]     req_op,
    input  logic [2*W-1:0] req_a,
    input  logic [2*W-1:0] req_b,
    output logic [1:0]     resp_valid,
    input  logic [1:0]     resp_ready,
    output logic [W-1:0]   resp_data,
    output logic           resp_err,
    output logic           alu_start,
    output logic [4:0]     alu_op,
    output logic [W-1:0]   alu_a,
    output logic [W-1:0]   alu_b,
    input  logic           alu_done,
    input  logic [W-1:0]   alu_result
);
    localparam int TW = $clog2(TIMEOUT + 1);
    localparam logic [TW-1:0] TIMER_LAST = TW'(TIMEOUT - 1);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ISSUE = 2'd1;
    localparam logic [1:0] S_WAIT  = 2'd2;
    localparam logic [1:0] S_RESP  = 2'd3;

    logic [1:0]    state_q, state_d;
    logic          rr_q, rr_d;          // index of the last requester served
    logic          owner_q, owner_d;
    logic [4:0]    op_q, op_d;
    logic [W-1:0]  a_q, a_d;
    logic [W-1:0]  b_q, b_d;
    logic [TW-1:0] timer_q, timer_d;
    logic [W-1:0]  data_q, data_d;
    logic          err_q, err_d;

    logic [1:0]    gnt;
    logic          acc;
    logic          acc_id;
    logic [4:0]    sel_op;
    logic [W-1:0]  sel_a;
    logic [W-1:0]  sel_b;

    function automatic logic op_legal(input logic [4:0] op);
        case (op)
            5'h00, 5'h01, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
            5'h0B, 5'h0C, 5'h12, 5'h13, 5'h14, 5'h15, 5'h16, 5'h17: op_legal = 1'b1;
            default: op_legal = 1'b0;
        endcase
    endfunction

    // Round-robin pick: a lone requester wins, a tie goes to the one not served last.
    always_comb begin
        gnt = 2'b00;
        case (req_valid)
            2'b01:   gnt = 2'b01;
            2'b10:   gnt = 2'b10;
            2'b11:   gnt = rr_q ? 2'b01 : 2'b10;
            default: gnt = 2'b00;
        endcase
    end

    assign req_ready = (state_q == S_IDLE) ? gnt : 2'b00;
    assign acc       = |(req_valid & req_ready);
    assign acc_id    = req_ready[1];
    assign sel_op    = acc_id ? req_op[9:5]       : req_op[4:0];
    assign sel_a     = acc_id ? req_a[2*W-1:W]    : req_a[W-1:0];
    assign sel_b     = acc_id ? req_b[2*W-1:W]    : req_b[W-1:0];

    assign alu_start  = (state_q == S_ISSUE);
    assign alu_op     = op_q;
    assign alu_a      = a_q;
    assign alu_b      = b_q;
    assign resp_valid = (state_q == S_RESP) ? (owner_q ? 2'b10 : 2'b01) : 2'b00;
    assign resp_data  = data_q;
    assign resp_err   = err_q;

    // Sequencer: accept -> launch -> wait for done or timeout -> hold response.
    always_comb begin
        state_d = state_q;
        rr_d    = rr_q;
        owner_d = owner_q;
        op_d    = op_q;
        a_d     = a_q;
        b_d     = b_q;
        timer_d = timer_q;
        data_d  = data_q;
        err_d   = err_q;
        case (state_q)
            S_IDLE: begin
                if (acc) begin
                    owner_d = acc_id;
                    rr_d    = acc_id;
                    if (op_legal(sel_op)) begin
                        // Only legal ops reach the ALU port registers.
                        op_d    = sel_op;
                        a_d     = sel_a;
                        b_d     = sel_b;
                        state_d = S_ISSUE;
                    end else begin
                        data_d  = '0;
                        err_d   = 1'b1;
                        state_d = S_RESP;
                    end
                end
            end
            S_ISSUE: begin
                timer_d = '0;
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (alu_done) begin
                    data_d  = alu_result;
                    err_d   = 1'b0;
                    state_d = S_RESP;
                end else if (timer_q == TIMER_LAST) begin
                    data_d  = '0;
                    err_d   = 1'b1;
                    state_d = S_RESP;
                end else begin
                    timer_d = timer_q + 1'b1;
                end
            end
            default: begin
                if (resp_ready[owner_q]) begin
                    state_d = S_IDLE;
                end
            end
        endcase
    end

    // State registers; reset abandons any op in flight without a response.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_IDLE;
            rr_q    <= 1'b1;
            owner_q <= 1'b0;
            op_q    <= '0;
            a_q     <= '0;
            b_q     <= '0;
            timer_q <= '0;
            data_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            rr_q    <= rr_d;
            owner_q <= owner_d;
            op_q    <= op_d;
            a_q     <= a_d;
            b_q     <= b_d;
            timer_q <= timer_d;
            data_q  <= data_d;
            err_q   <= err_d;
        end
    end
endmodule

// File: tb/tb_alu_share_arb.sv
// tb_alu_share_arb: directed bench with a transaction-level reference model
// checked every cycle, plus hand-computed expectations for each scenario.
module tb_alu_share_arb;
    localparam int W       = 16;
    localparam int TIMEOUT = 16;

    logic           clk        = 1'b0;
    logic           rst_n      = 1'b1;
    logic [1:0]     req_valid  = 2'b00;
    logic [9:0]     req_op     = '0;
    logic [2*W-1:0] req_a      = '0;
    logic [2*W-1:0] req_b      = '0;
    logic [1:0]     resp_ready = 2'b00;
    logic [1:0]     req_ready;
    logic [1:0]     resp_valid;
    logic [W-1:0]   resp_data;
    logic           resp_err;
    logic           alu_start;
    logic [4:0]     alu_op;
    logic [W-1:0]   alu_a;
    logic [W-1:0]   alu_b;
    logic           alu_done;
    logic [W-1:0]   alu_result;

    always #5 clk = ~clk;

    alu_share_arb #(.W(W), .TIMEOUT(TIMEOUT)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .req_valid  (req_valid),
        .req_ready  (req_ready),
        .req_op     (req_op),
        .req_a      (req_a),
        .req_b      (req_b),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_data  (resp_data),
        .resp_err   (resp_err),
        .alu_start  (alu_start),
        .alu_op     (alu_op),
        .alu_a      (alu_a),
        .alu_b      (alu_b),
        .alu_done   (alu_done),
        .alu_result (alu_result)
    );

    // Arbitrary ALU function for the stand-in; ADD is real addition.
    function automatic logic [W-1:0] alu_fn(input logic [4:0] op, input logic [W-1:0] a,
                                            input logic [W-1:0] b);
        if (op == 5'h00) return a + b;
        return (a - b) ^ {{(W-5){1'b0}}, op};
    endfunction

    function automatic logic is_legal(input logic [4:0] op);
        return op inside {5'h00, 5'h01, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07, 5'h08, 5'h09,
                          5'h0B, 5'h0C, [5'h12:5'h17]};
    endfunction

    function automatic int pick(input logic [1:0] v, input int last);
        if (v == 2'b01) return 0;
        if (v == 2'b10) return 1;
        if (v == 2'b11) return (last == 1) ? 0 : 1;
        return -1;
    endfunction

    // ALU stand-in: done arrives alu_lat cycles after the start pulse (0 = never).
    int   alu_lat    = 0;
    int   pend       = 0;
    logic force_done = 1'b0;
    always @(posedge clk) begin
        if (alu_start) pend <= alu_lat;
        else if (pend > 0) pend <= pend - 1;
    end
    assign alu_done   = (pend == 1) || force_done;
    assign alu_result = alu_fn(alu_op, alu_a, alu_b);

    // Observers: start pulses and the sequence of granted requesters.
    int n_start = 0;
    int gq[$];
    always @(negedge clk) begin
        if (rst_n && alu_start) n_start <= n_start + 1;
        if (rst_n && ((req_valid & req_ready) != 2'b00)) gq.push_back(req_ready[1] ? 1 : 0);
    end

    function automatic int count_gq(input int id, input int from);
        int c = 0;
        for (int i = from; i < gq.size(); i++) if (gq[i] == id) c++;
        return c;
    endfunction

    // Reference model: one op in flight, age counted from the launch cycle.
    logic       m_busy, m_resp, m_legal, m_err;
    int         m_owner, m_age, m_last;
    logic [4:0] m_op;
    logic [W-1:0] m_a, m_b, m_data;
    int         m_pick;
    logic [4:0] pick_op;
    logic [W-1:0] pick_a, pick_b;

    always_comb begin
        m_pick  = pick(req_valid, m_last);
        pick_op = (m_pick == 1) ? req_op[9:5] : req_op[4:0];
        pick_a  = (m_pick == 1) ? req_a[2*W-1:W] : req_a[W-1:0];
        pick_b  = (m_pick == 1) ? req_b[2*W-1:W] : req_b[W-1:0];
    end

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            m_busy <= 1'b0; m_resp <= 1'b0; m_legal <= 1'b0; m_err <= 1'b0;
            m_owner <= 0; m_age <= 0; m_last <= 1;
            m_op <= '0; m_a <= '0; m_b <= '0; m_data <= '0;
        end else if (!m_busy) begin
            if (m_pick >= 0) begin
                m_busy  <= 1'b1;
                m_owner <= m_pick;
                m_last  <= m_pick;
                m_age   <= 0;
                m_legal <= is_legal(pick_op);
                if (is_legal(pick_op)) begin
                    m_op <= pick_op; m_a <= pick_a; m_b <= pick_b; m_resp <= 1'b0;
                end else begin
                    m_resp <= 1'b1; m_data <= '0; m_err <= 1'b1;
                end
            end
        end else if (!m_resp) begin
            if (m_age >= 1) begin
                if (alu_done) begin
                    m_resp <= 1'b1; m_data <= alu_fn(m_op, m_a, m_b); m_err <= 1'b0;
                end else if (m_age - 1 == TIMEOUT - 1) begin
                    m_resp <= 1'b1; m_data <= '0; m_err <= 1'b1;
                end
            end
            m_age <= m_age + 1;
        end else if (resp_ready[m_owner]) begin
            m_busy <= 1'b0;
            m_resp <= 1'b0;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic cmp_model();
        logic [1:0] e_rdy, e_rv;
        logic       e_start;
        e_rdy   = (m_busy || m_pick < 0) ? 2'b00 : ((m_pick == 1) ? 2'b10 : 2'b01);
        e_rv    = m_resp ? ((m_owner == 1) ? 2'b10 : 2'b01) : 2'b00;
        e_start = m_busy && !m_resp && m_legal && (m_age == 0);
        check("mdl_req_ready",  64'(req_ready),  64'(e_rdy));
        check("mdl_resp_valid", 64'(resp_valid), 64'(e_rv));
        check("mdl_resp_data",  64'(resp_data),  64'(m_data));
        check("mdl_resp_err",   64'(resp_err),   64'(m_err));
        check("mdl_alu_start",  64'(alu_start),  64'(e_start));
        check("mdl_alu_op",     64'(alu_op),     64'(m_op));
        check("mdl_alu_a",      64'(alu_a),      64'(m_a));
        check("mdl_alu_b",      64'(alu_b),      64'(m_b));
    endtask

    task automatic tick();
        @(negedge clk);
        cmp_model();
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input int id, input logic [4:0] op, input logic [W-1:0] a,
                         input logic [W-1:0] b);
        logic r;
        int   ok;
        ok = 0;
        req_op[5*id +: 5] = op;
        req_a[W*id +: W]  = a;
        req_b[W*id +: W]  = b;
        req_valid[id]     = 1'b1;
        for (int n = 0; n < 50; n++) begin
            #1;
            r = req_ready[id];
            tick();
            if (r) begin
                ok = 1;
                break;
            end
        end
        req_valid[id] = 1'b0;
        check("accept_seen", 64'(ok), 64'd1);
    endtask

    task automatic wait_resp(output int k);
        k = 1;
        while (resp_valid == 2'b00 && k < 100) begin
            tick();
            k++;
        end
        check("resp_arrives", 64'(resp_valid != 2'b00), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int k;
        int n0;
        int base;
        int got;
        rst_n = 1'b0;
        repeat (3) tick();
        check("rst_resp_valid", 64'(resp_valid), 64'd0);
        check("rst_alu_start",  64'(alu_start),  64'd0);
        check("rst_resp_data",  64'(resp_data),  64'd0);
        rst_n = 1'b1;
        tick();

        // Reset in the middle of a wait
        alu_lat = 0;
        issue(0, 5'h03, 16'd10, 16'd4);
        repeat (3) tick();
        #2 rst_n = 1'b0;
        #1;
        check("t1_req_ready",  64'(req_ready),  64'd0);
        check("t1_resp_valid", 64'(resp_valid), 64'd0);
        check("t1_alu_start",  64'(alu_start),  64'd0);
        check("t1_alu_op",     64'(alu_op),     64'd0);
        check("t1_alu_a",      64'(alu_a),      64'd0);
        check("t1_resp_err",   64'(resp_err),   64'd0);
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t1_no_resp", 64'(resp_valid), 64'd0);
        end

        // ADD 5+3, done two cycles after start
        alu_lat = 2;
        issue(0, 5'h00, 16'd5, 16'd3);
        wait_resp(k);
        check("t2_latency",    64'(k),          64'd4);
        check("t2_resp_valid", 64'(resp_valid), 64'd1);
        check("t2_resp_data",  64'(resp_data),  64'd8);
        check("t2_resp_err",   64'(resp_err),   64'd0);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        check("t2_resp_cleared", 64'(resp_valid), 64'd0);

        // Both requesters hammering: grants must alternate starting at 0
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        tick();
        alu_lat    = 1;
        resp_ready = 2'b11;
        base       = gq.size();
        req_op     = {5'h13, 5'h04};
        req_valid  = 2'b11;
        for (int n = 0; n < 300 && req_valid != 2'b00; n++) begin
            req_a = {16'(n * 3), 16'(n)};
            req_b = {16'(n + 7), 16'd2};
            tick();
            if (count_gq(0, base) >= 4) req_valid[0] = 1'b0;
            if (count_gq(1, base) >= 4) req_valid[1] = 1'b0;
        end
        req_valid = 2'b00;
        repeat (8) tick();
        resp_ready = 2'b00;
        check("t3_grant_count", 64'(gq.size() - base), 64'd8);
        for (int i = 0; i < 8; i++) begin
            got = (base + i < gq.size()) ? gq[base + i] : 9;
            check("t3_grant_order", 64'(got), 64'(i % 2));
        end

        // Illegal opcode from requester 1
        n0 = n_start;
        issue(1, 5'h1F, 16'h1234, 16'h0042);
        check("t4_resp_valid", 64'(resp_valid), 64'd2);
        check("t4_resp_data",  64'(resp_data),  64'd0);
        check("t4_resp_err",   64'(resp_err),   64'd1);
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;
        tick();
        check("t4_no_start",   64'(n_start),    64'(n0));
        check("t4_resp_done",  64'(resp_valid), 64'd0);

        // ALU never answers: timeout, then a late done is ignored
        alu_lat = 0;
        issue(0, 5'h05, 16'd100, 16'd7);
        wait_resp(k);
        check("t5_latency",   64'(k),         64'(TIMEOUT + 2));
        check("t5_resp_err",  64'(resp_err),  64'd1);
        check("t5_resp_data", 64'(resp_data), 64'd0);
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        check("t5_late_done_data", 64'(resp_data), 64'd0);
        check("t5_late_done_err",  64'(resp_err),  64'd1);
        resp_ready = 2'b01;
        tick();
        resp_ready = 2'b00;
        n0 = n_start;
        force_done = 1'b1;
        tick();
        force_done = 1'b0;
        tick();
        check("t5_idle_done_ignored", 64'(resp_valid), 64'd0);
        check("t5_idle_no_start",     64'(n_start),    64'(n0));

        // Response held back for five cycles while both requesters wait
        alu_lat = 3;
        issue(1, 5'h16, 16'd40, 16'd2);
        wait_resp(k);
        check("t6_latency",   64'(k),         64'd5);
        check("t6_resp_data", 64'(resp_data), 64'd48);
        n0        = n_start;
        req_op    = {5'h00, 5'h01};
        req_valid = 2'b11;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t6_hold_valid", 64'(resp_valid), 64'd2);
            check("t6_hold_data",  64'(resp_data),  64'd48);
            check("t6_no_ready",   64'(req_ready),  64'd0);
        end
        resp_ready = 2'b01;
        tick();
        check("t6_nonowner_ready", 64'(resp_valid), 64'd2);
        resp_ready = 2'b10;
        tick();
        resp_ready = 2'b00;
        req_valid  = 2'b00;
        check("t6_single_start", 64'(n_start), 64'(n0));
        repeat (3) tick();

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
